octave_sched: RTL

- Schedules octave changes for the multi-stage binary clock divider.
- Accepts a requested octave (0..7) from the front panel/MIDI logic over a valid/ready handshake.
- Drives the divider's 3-bit octave select so that it only changes on a common phase boundary of all divide taps, preventing runt pulses on the selected divided clock.
- Optionally glides one octave per boundary, with a programmable dwell between steps.

---
 rtl/octave_sched.sv | 121 ++++++++++++
 1 files changed

// File: rtl/octave_sched.sv
// Octave select scheduler for the binary clock divider: octave changes land only
// on the common /256 phase boundary, optionally gliding one octave per dwell period.
module octave_sched #(
    parameter logic [2:0]  OCT_RESET     = 3'd0,
    parameter int unsigned STEP_MODE     = 1,
    parameter int unsigned DWELL_PERIODS = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] req_octave,
    input  logic       req_valid,
    output logic       req_ready,
    output logic [2:0] octave,
    output logic [7:0] phase,
    output logic       busy,
    output logic       step_pulse
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ALIGN,
        DWELL
    } state_t;

    localparam logic [3:0] DWELL_LOAD = 4'(DWELL_PERIODS - 1);

    state_t     state, state_nxt;
    logic [2:0] target, target_nxt;
    logic [2:0] octave_nxt;
    logic [2:0] step_oct;
    logic [3:0] dwell, dwell_nxt;
    logic       pulse_nxt;
    logic       take_step;
    logic       boundary;
    logic       accept;

    assign boundary  = (phase == 8'hFF);
    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = req_valid && req_ready;

    // Octave moves monotonically toward target, so comparing each step keeps
    // the direction chosen at acceptance.
    always_comb begin
        step_oct = target;
        if (STEP_MODE != 0) begin
            if (target > octave) begin
                step_oct = octave + 3'd1;
            end else begin
                step_oct = octave - 3'd1;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        target_nxt = target;
        octave_nxt = octave;
        dwell_nxt  = dwell;
        pulse_nxt  = 1'b0;
        take_step  = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    target_nxt = req_octave;
                    if (req_octave != octave) begin
                        state_nxt = WAIT_ALIGN;
                    end
                end
            end
            WAIT_ALIGN: begin
                if (boundary) begin
                    take_step = 1'b1;
                end
            end
            DWELL: begin
                if (boundary) begin
                    if (dwell == 4'd0) begin
                        take_step = 1'b1;
                    end else begin
                        dwell_nxt = dwell - 4'd1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (take_step) begin
            octave_nxt = step_oct;
            pulse_nxt  = 1'b1;
            if (step_oct == target) begin
                state_nxt = IDLE;
            end else begin
                dwell_nxt = DWELL_LOAD;
                state_nxt = DWELL;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            target     <= OCT_RESET;
            octave     <= OCT_RESET;
            dwell      <= '0;
            phase      <= '0;
            step_pulse <= 1'b0;
        end else begin
            state      <= state_nxt;
            target     <= target_nxt;
            octave     <= octave_nxt;
            dwell      <= dwell_nxt;
            phase      <= phase + 8'd1;
            step_pulse <= pulse_nxt;
        end
    end

endmodule
